// File: rtl/e203_exu_flush_buf.sv
// Single-entry flush buffer between commit and IFU: registers the flush target PC
// and holds the request until the IFU acknowledges; also counts accepted flushes.
module e203_exu_flush_buf #(
   parameter int unsigned PC_SIZE = 32,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmt_flush_req,
   input  logic [PC_SIZE-1:0] cmt_flush_add_op1,
   input  logic [PC_SIZE-1:0] cmt_flush_add_op2,
   output logic               cmt_flush_ack,
   output logic               ifu_flush_req,
   output logic [PC_SIZE-1:0] ifu_flush_pc,
   input  logic               ifu_flush_ack,
   output logic               flush_pending,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef enum logic {StIdle, StPend} state_e;

   state_e             state_q, state_d;
   logic [PC_SIZE-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PC_SIZE-1:0] sum;
   logic               pend;
   logic               accept;

   assign pend   = (state_q == StPend);
   // Ack comes from state alone so there is no comb path back to the commit stage.
   assign accept = cmt_flush_req & ~pend;
   assign sum    = cmt_flush_add_op1 + cmt_flush_add_op2;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StPend;
               pc_d    = {sum[PC_SIZE-1:1], 1'b0};
            end
         end
         StPend: begin
            if (ifu_flush_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = accept ? CNT_W'(1) : '0;
      end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cmt_flush_ack = ~pend;
   assign ifu_flush_req = pend;
   assign flush_pending = pend;
   assign ifu_flush_pc  = pc_q;
   assign flush_cnt     = cnt_q;

endmodule

// File: tb/tb_e203_exu_flush_buf.sv
// Directed bench for e203_exu_flush_buf: vector table plus hand-written corner sequences.
module tb_e203_exu_flush_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmt_flush_req;
   logic [31:0] cmt_flush_add_op1;
   logic [31:0] cmt_flush_add_op2;
   logic        cmt_flush_ack;
   logic        ifu_flush_req;
   logic [31:0] ifu_flush_pc;
   logic        ifu_flush_ack;
   logic        flush_pending;
   logic        cnt_clr;
   logic [7:0]  flush_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   e203_exu_flush_buf #(
      .PC_SIZE(32),
      .CNT_W  (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cmt_flush_req    (cmt_flush_req),
      .cmt_flush_add_op1(cmt_flush_add_op1),
      .cmt_flush_add_op2(cmt_flush_add_op2),
      .cmt_flush_ack    (cmt_flush_ack),
      .ifu_flush_req    (ifu_flush_req),
      .ifu_flush_pc     (ifu_flush_pc),
      .ifu_flush_ack    (ifu_flush_ack),
      .flush_pending    (flush_pending),
      .cnt_clr          (cnt_clr),
      .flush_cnt        (flush_cnt)
   );

   typedef struct {
      logic        req;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        iack;
      logic        clr;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_cack;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic e_req, input logic [31:0] e_pc,
                          input logic [7:0] e_cnt);
      chk({nm, ".ifu_req"}, {31'b0, ifu_flush_req}, {31'b0, e_req});
      chk({nm, ".pending"}, {31'b0, flush_pending}, {31'b0, e_req});
      chk({nm, ".cmt_ack"}, {31'b0, cmt_flush_ack}, {31'b0, ~e_req});
      chk({nm, ".pc"}, ifu_flush_pc, e_pc);
      chk({nm, ".cnt"}, {24'b0, flush_cnt}, {24'b0, e_cnt});
   endtask

   task automatic idle_inputs();
      cmt_flush_req     = 1'b0;
      cmt_flush_add_op1 = '0;
      cmt_flush_add_op2 = '0;
      ifu_flush_ack     = 1'b0;
      cnt_clr           = 1'b0;
   endtask

   logic [31:0] held_pc;

   initial begin
      //          req  op1           op2           iack clr  e_req e_pc          e_cack e_cnt
      vecs[0]  = '{1'b1, 32'h8000_0100, 32'h0000_0024, 1'b0, 1'b0, 1'b1, 32'h8000_0124, 1'b0, 8'd1};
      vecs[1]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h8000_0124, 1'b0, 8'd1};
      vecs[2]  = '{1'b1, 32'h0000_1111, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0124, 1'b0, 8'd1};
      vecs[3]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h8000_0124, 1'b1, 8'd1};
      vecs[4]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h8000_0124, 1'b1, 8'd1};
      vecs[5]  = '{1'b1, 32'hFFFF_FFF0, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'd2};
      vecs[6]  = '{1'b1, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 1'b1, 8'd2};
      vecs[7]  = '{1'b1, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 8'd3};
      vecs[8]  = '{1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 8'd3};
      vecs[9]  = '{1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 32'h0000_000A, 1'b0, 8'd4};
      vecs[10] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_000A, 1'b0, 8'd0};
      vecs[11] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_000A, 1'b1, 8'd0};
      vecs[12] = '{1'b1, 32'h0000_0007, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0006, 1'b0, 8'd1};

      // Reset, then idle.
      idle_inputs();
      rst = 1'b1;
      repeat (3) step();
      chk_all("reset", 1'b0, 32'h0, 8'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_all("idle", 1'b0, 32'h0, 8'd0);
      end

      // Vector table.
      for (int i = 0; i < 13; i++) begin
         cmt_flush_req     = vecs[i].req;
         cmt_flush_add_op1 = vecs[i].op1;
         cmt_flush_add_op2 = vecs[i].op2;
         ifu_flush_ack     = vecs[i].iack;
         cnt_clr           = vecs[i].clr;
         step();
         chk($sformatf("vec%0d.ifu_req", i), {31'b0, ifu_flush_req}, {31'b0, vecs[i].e_req});
         chk($sformatf("vec%0d.pc", i), ifu_flush_pc, vecs[i].e_pc);
         chk($sformatf("vec%0d.cmt_ack", i), {31'b0, cmt_flush_ack}, {31'b0, vecs[i].e_cack});
         chk($sformatf("vec%0d.cnt", i), {24'b0, flush_cnt}, {24'b0, vecs[i].e_cnt});
      end

      // Drain the flush left pending by the table, clear the counter.
      idle_inputs();
      ifu_flush_ack = 1'b1;
      cnt_clr       = 1'b1;
      step();
      chk_all("drain_clr", 1'b0, 32'h6, 8'd0);

      // Back-to-back: req and ack held high, accepts on every second edge.
      cnt_clr       = 1'b0;
      cmt_flush_req = 1'b1;
      ifu_flush_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmt_flush_add_op1 = 32'h1000 * (i + 1);
         cmt_flush_add_op2 = 32'h4;
         step();
         chk($sformatf("b2b%0d.ifu_req", i), {31'b0, ifu_flush_req}, {31'b0, (i % 2) == 0});
      end
      chk("b2b.pc", ifu_flush_pc, 32'h7004);
      chk("b2b.cnt", {24'b0, flush_cnt}, 32'd4);

      // Hold: ops change during PEND with no ack, pc must stay frozen.
      cmt_flush_add_op1 = 32'h2000_0000;
      cmt_flush_add_op2 = 32'h0000_0010;
      ifu_flush_ack     = 1'b0;
      step();
      chk_all("hold_acc", 1'b1, 32'h2000_0010, 8'd5);
      for (int i = 0; i < 5; i++) begin
         cmt_flush_add_op1 = 32'hABC0_0000 + i;
         cmt_flush_add_op2 = 32'h0000_1235 * i;
         step();
         chk($sformatf("hold%0d.pc", i), ifu_flush_pc, 32'h2000_0010);
         chk($sformatf("hold%0d.ifu_req", i), {31'b0, ifu_flush_req}, 32'd1);
      end
      idle_inputs();
      ifu_flush_ack = 1'b1;
      step();
      chk_all("hold_drain", 1'b0, 32'h2000_0010, 8'd5);

      // Counter saturation after 260 accepts.
      idle_inputs();
      cnt_clr = 1'b1;
      step();
      chk("cnt_clr0", {24'b0, flush_cnt}, 32'd0);
      cnt_clr = 1'b0;
      for (int i = 0; i < 260; i++) begin
         cmt_flush_req = 1'b1;
         ifu_flush_ack = 1'b0;
         cmt_flush_add_op1 = 32'(i);
         step();
         cmt_flush_req = 1'b0;
         ifu_flush_ack = 1'b1;
         step();
         if (i == 254) chk("cnt_at255", {24'b0, flush_cnt}, 32'd255);
      end
      chk("cnt_sat", {24'b0, flush_cnt}, 32'd255);
      chk("cnt_sat.pc", ifu_flush_pc, 32'd258);
      cmt_flush_req = 1'b1;
      ifu_flush_ack = 1'b0;
      cnt_clr       = 1'b1;
      step();
      chk_all("clr_acc", 1'b1, 32'h0000_0102, 8'd1);
      idle_inputs();
      ifu_flush_ack = 1'b1;
      step();
      cnt_clr       = 1'b1;
      ifu_flush_ack = 1'b0;
      step();
      chk_all("clr_alone", 1'b0, 32'h0000_0102, 8'd0);

      // Asynchronous reset in the middle of a pending flush.
      idle_inputs();
      cmt_flush_req     = 1'b1;
      cmt_flush_add_op1 = 32'h4000_0000;
      cmt_flush_add_op2 = 32'h0000_0008;
      step();
      chk("rst_mid.pre_req", {31'b0, ifu_flush_req}, 32'd1);
      cmt_flush_req = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk_all("rst_mid.async", 1'b0, 32'h0, 8'd0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("rst_mid.after", 1'b0, 32'h0, 8'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/e203_exu_flush_buf.md
# e203_exu_flush_buf

Single-entry flush buffer between the commit stage and the IFU. It accepts the commit stage's flush request as an adder-operand pair, computes the flush target PC once, and holds it as a registered request to the IFU until the IFU acknowledges. This cuts the combinational path from commit-side flush generation to IFU PC selection. It also keeps a saturating count of accepted flushes for performance monitoring.

## Interface

Parameters:
- PC_SIZE, 32, width of PC and of both adder operands.
- CNT_W, 8, width of the saturating flush counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high. All state clears immediately on assertion.
- cmt_flush_req  in  1  flush request from the commit stage.
- cmt_flush_add_op1  in  PC_SIZE  first flush-target operand. Valid when cmt_flush_req is high.
- cmt_flush_add_op2  in  PC_SIZE  second flush-target operand. Valid when cmt_flush_req is high.
- cmt_flush_ack  out  1  flush accepted. Equals ~pend and never depends on cmt_flush_req.
- ifu_flush_req  out  1  registered flush request to the IFU. Equals pend.
- ifu_flush_pc  out  PC_SIZE  registered flush target.
- ifu_flush_ack  in  1  IFU accepts the flush in this cycle.
- flush_pending  out  1  same as pend. Used by fetch to suppress new requests.
- cnt_clr  in  1  synchronous clear of the flush counter.
- flush_cnt  out  CNT_W  number of accepted flushes, saturating.

## Operation

- Two states, held in one flop pend: IDLE (pend=0) and PEND (pend=1).
- Accept: accept = cmt_flush_req & cmt_flush_ack. An accept can occur only in IDLE.
- On accept:
  - pc_r <= (cmt_flush_add_op1 + cmt_flush_add_op2), with bit 0 forced to 0.
  - The sum is modulo 2^PC_SIZE; carry out is discarded.
  - pend <= 1.
- IDLE -> PEND on accept. IDLE with cmt_flush_req=0: no change.
- PEND -> IDLE on ifu_flush_ack. PEND without ack: hold. pc_r is frozen, and the op inputs and cmt_flush_req are ignored.
- There is no bypass path from ifu_flush_ack to cmt_flush_ack. A new flush cannot be accepted in the same cycle the pending one drains.
- pc_r keeps its last value after draining. It updates only on accept.
- ifu_flush_ack while in IDLE is ignored.
- Counter update:
  - Accept and ~cnt_clr: flush_cnt increments, saturating at 2^CNT_W-1 (never wraps).
  - cnt_clr and ~accept: flush_cnt <= 0.
  - cnt_clr and accept in the same cycle: flush_cnt <= 1.
- Reset values: pend=0, ifu_flush_req=0, flush_pending=0, cmt_flush_ack=1, ifu_flush_pc=0, flush_cnt=0.
- Reset asserted mid-PEND discards the pending flush. No request is issued after reset deasserts.

## Timing

- cmt_flush_ack is combinational from pend only.
- ifu_flush_req and ifu_flush_pc are pure flop outputs.
- Latency: accept at edge N gives ifu_flush_req=1 and a valid ifu_flush_pc from edge N through at least cycle N+1.
- Drain: ifu_flush_ack high at edge M gives ifu_flush_req=0 and cmt_flush_ack=1 after M. The earliest next accept is edge M+1.
- Minimum spacing between accepts is 2 cycles, reached when the IFU acks in the first PEND cycle.
- ifu_flush_pc is stable for the entire interval where ifu_flush_req is high.
- The adder is the only deep combinational path: op inputs to the pc_r D pin.

## Test plan

- Reset then idle:
  - Stimulus: hold rst for 3 cycles.
  - Required: cmt_flush_ack=1, ifu_flush_req=0, ifu_flush_pc=0, flush_cnt=0.
  - Then with rst deasserted and all inputs held 0 for 10 cycles: all outputs unchanged.
- Basic flush:
  - Stimulus: op1=0x8000_0100, op2=0x0000_0024, req for 1 cycle.
  - Required next cycle: ifu_flush_req=1, ifu_flush_pc=0x8000_0124, cmt_flush_ack=0.
  - Then ack after 3 cycles: req drops the following cycle, flush_cnt=1.
- Odd sum and wrap:
  - Stimulus: op1=0xFFFF_FFF0, op2=0x0000_0013.
  - Required: ifu_flush_pc=0x0000_0002 (bit 0 cleared, carry dropped).
- Back-to-back and hold:
  - Stimulus: cmt_flush_req held high continuously; ifu_flush_ack held high continuously.
  - Required: accepts every 2nd cycle.
  - Separately, with ops changed during PEND and ack held low: ifu_flush_pc unchanged.
- Counter edges:
  - Stimulus: 260 accepts.
  - Required: flush_cnt=255.
  - Then cnt_clr coincident with an accept: flush_cnt=1. cnt_clr alone: flush_cnt=0.
- Reset mid-PEND:
  - Stimulus: accept a flush, then assert rst asynchronously, between clock edges, before any ack.
  - Required: ifu_flush_req falls immediately without a clock edge, and remains 0 after release.
